// File: rtl/pll_md_responder_if.sv
// MD (dynamic-reconfiguration) port bundle between the PLL initiator and the
// PLL-side responder, plus the responder's lock and active-configuration outputs.
interface pll_md_responder_if;
  logic [1:0] mdopc;
  logic       mdainc;
  logic [7:0] mdwdi;
  logic [7:0] mdrdo;
  logic       lock;
  logic [7:0] cfg_mult;
  logic [7:0] cfg_idiv;
  logic [7:0] cfg_odiv;
  logic       commit_pulse;

  modport master (
    output mdopc,
    output mdainc,
    output mdwdi,
    input  mdrdo,
    input  lock,
    input  cfg_mult,
    input  cfg_idiv,
    input  cfg_odiv,
    input  commit_pulse
  );

  modport slave (
    input  mdopc,
    input  mdainc,
    input  mdwdi,
    output mdrdo,
    output lock,
    output cfg_mult,
    output cfg_idiv,
    output cfg_odiv,
    output commit_pulse
  );
endinterface

// File: rtl/pll_md_responder.sv
// PLL-side MD-port responder: shadow register file, commit of MULT/IDIV/ODIV0 to
// the active configuration, and a settle counter that models PLL lock.
module pll_md_responder #(
  parameter int DEPTH       = 16,
  parameter int MULT_RST    = 12,
  parameter int IDIV_RST    = 1,
  parameter int ODIV_RST    = 1,
  parameter int LOCK_CYCLES = 64
) (
  input  logic              mdclk,
  input  logic              reset,
  pll_md_responder_if.slave md
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LOCK_CYCLES) + 1;
  localparam logic [AW-1:0] CTRL_ADDR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_ADDR  = 2'b11
  } op_e;

  typedef enum logic {
    ST_SETTLE = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  function automatic logic [7:0] reg_rst(input int idx);
    logic [7:0] val;
    case (idx)
      0:       val = 8'(MULT_RST);
      1:       val = 8'(IDIV_RST);
      2:       val = 8'(ODIV_RST);
      default: val = 8'h00;
    endcase
    return val;
  endfunction

  op_e             op_s;
  logic            is_ctrl_s;
  logic            commit_s;

  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      regs_q [DEPTH];
  logic [7:0]      regs_d [DEPTH];
  logic [7:0]      mdrdo_q, mdrdo_d;
  logic [7:0]      cfg_mult_q, cfg_mult_d;
  logic [7:0]      cfg_idiv_q, cfg_idiv_d;
  logic [7:0]      cfg_odiv_q, cfg_odiv_d;
  logic            commit_pulse_q, commit_pulse_d;
  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            lock_q, lock_d;

  // MD port decode: address pointer, register file writes, read data, commit detect
  always_comb begin
    op_s      = op_e'(md.mdopc);
    is_ctrl_s = (addr_q == CTRL_ADDR);
    addr_d    = addr_q;
    regs_d    = regs_q;
    mdrdo_d   = mdrdo_q;
    commit_s  = 1'b0;
    case (op_s)
      OP_NOP: begin
        addr_d = addr_q;
      end
      OP_ADDR: begin
        addr_d = md.mdwdi[AW-1:0];
      end
      OP_WRITE: begin
        // CTRL is write-only and never stored; only bit 0 means anything
        if (is_ctrl_s) begin
          commit_s = md.mdwdi[0];
        end else begin
          regs_d[addr_q] = md.mdwdi;
        end
        if (md.mdainc) begin
          addr_d = addr_q + AW'(1);
        end else begin
          addr_d = addr_q;
        end
      end
      OP_READ: begin
        if (is_ctrl_s) begin
          mdrdo_d = 8'h00;
        end else begin
          mdrdo_d = regs_q[addr_q];
        end
        if (md.mdainc) begin
          addr_d = addr_q + AW'(1);
        end else begin
          addr_d = addr_q;
        end
      end
      default: begin
        addr_d = addr_q;
      end
    endcase
  end

  // Active configuration follows the shadow registers as they stood before the commit edge
  always_comb begin
    cfg_mult_d     = cfg_mult_q;
    cfg_idiv_d     = cfg_idiv_q;
    cfg_odiv_d     = cfg_odiv_q;
    commit_pulse_d = commit_s;
    if (commit_s) begin
      cfg_mult_d = regs_q[0];
      cfg_idiv_d = regs_q[1];
      cfg_odiv_d = regs_q[2];
    end else begin
      cfg_mult_d = cfg_mult_q;
      cfg_idiv_d = cfg_idiv_q;
      cfg_odiv_d = cfg_odiv_q;
    end
  end

  // Lock model next state: a commit always restarts settling, even mid-settle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lock_d  = lock_q;
    if (commit_s) begin
      state_d = ST_SETTLE;
      cnt_d   = '0;
      lock_d  = 1'b0;
    end else begin
      case (state_q)
        ST_SETTLE: begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_LOCKED;
            cnt_d   = cnt_q;
            lock_d  = 1'b1;
          end else begin
            state_d = ST_SETTLE;
            cnt_d   = cnt_q + CW'(1);
            lock_d  = 1'b0;
          end
        end
        ST_LOCKED: begin
          state_d = ST_LOCKED;
          cnt_d   = cnt_q;
          lock_d  = 1'b1;
        end
        default: begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
          lock_d  = 1'b0;
        end
      endcase
    end
  end

  // Register file and MD read path
  always_ff @(posedge mdclk) begin
    if (reset) begin
      addr_q  <= '0;
      mdrdo_q <= 8'h00;
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= reg_rst(i);
      end
    end else begin
      addr_q  <= addr_d;
      mdrdo_q <= mdrdo_d;
      regs_q  <= regs_d;
    end
  end

  // Active configuration and commit strobe
  always_ff @(posedge mdclk) begin
    if (reset) begin
      cfg_mult_q     <= 8'(MULT_RST);
      cfg_idiv_q     <= 8'(IDIV_RST);
      cfg_odiv_q     <= 8'(ODIV_RST);
      commit_pulse_q <= 1'b0;
    end else begin
      cfg_mult_q     <= cfg_mult_d;
      cfg_idiv_q     <= cfg_idiv_d;
      cfg_odiv_q     <= cfg_odiv_d;
      commit_pulse_q <= commit_pulse_d;
    end
  end

  // Lock FSM state register
  always_ff @(posedge mdclk) begin
    if (reset) begin
      state_q <= ST_SETTLE;
      cnt_q   <= '0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lock_q  <= lock_d;
    end
  end

  assign md.mdrdo        = mdrdo_q;
  assign md.lock         = lock_q;
  assign md.cfg_mult     = cfg_mult_q;
  assign md.cfg_idiv     = cfg_idiv_q;
  assign md.cfg_odiv     = cfg_odiv_q;
  assign md.commit_pulse = commit_pulse_q;

endmodule

// File: tb/tb_pll_md_responder.sv
// Bench for pll_md_responder: table-driven MD-port vectors with a read-data
// scoreboard, plus lock-timing and reset-abort sequences.
module tb_pll_md_responder;
  localparam int LOCK_CYCLES = 64;
  localparam logic [1:0] NOP = 2'b00;
  localparam logic [1:0] WR  = 2'b01;
  localparam logic [1:0] RD  = 2'b10;
  localparam logic [1:0] AD  = 2'b11;

  typedef struct {
    logic [1:0] opc;
    logic       ainc;
    logic [7:0] wdi;
    logic [7:0] exp_rd;
    logic       exp_commit;
    logic       exp_lock;
    logic [7:0] exp_mult;
    logic [7:0] exp_idiv;
    logic [7:0] exp_odiv;
  } vec_t;

  logic mdclk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   start = 0;
  logic [7:0] exp_hold = 8'h00;
  vec_t       vq[$];
  logic [7:0] rd_q[$];

  always #5 mdclk = ~mdclk;

  pll_md_responder_if md_if ();

  pll_md_responder #(
    .DEPTH(16), .MULT_RST(12), .IDIV_RST(1), .ODIV_RST(1), .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .mdclk(mdclk),
    .reset(reset),
    .md(md_if)
  );

  task automatic tick();
    @(posedge mdclk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic add(input logic [1:0] opc, input logic ainc, input logic [7:0] wdi,
                     input logic [7:0] rd, input logic cm, input logic lk,
                     input logic [7:0] m, input logic [7:0] i, input logic [7:0] o);
    vec_t v;
    v.opc = opc; v.ainc = ainc; v.wdi = wdi; v.exp_rd = rd; v.exp_commit = cm;
    v.exp_lock = lk; v.exp_mult = m; v.exp_idiv = i; v.exp_odiv = o;
    vq.push_back(v);
  endtask

  task automatic drive_nop();
    md_if.mdopc  = NOP;
    md_if.mdainc = 1'b0;
    md_if.mdwdi  = 8'h00;
  endtask

  task automatic run_table(input string tag);
    for (int k = 0; k < vq.size(); k++) begin
      vec_t v;
      v = vq[k];
      md_if.mdopc  = v.opc;
      md_if.mdainc = v.ainc;
      md_if.mdwdi  = v.wdi;
      if (v.opc == RD) rd_q.push_back(v.exp_rd);
      tick();
      if (rd_q.size() > 0) exp_hold = rd_q.pop_front();
      chk($sformatf("%s[%0d].mdrdo", tag, k), md_if.mdrdo, exp_hold);
      chk($sformatf("%s[%0d].commit_pulse", tag, k), md_if.commit_pulse, v.exp_commit);
      chk($sformatf("%s[%0d].lock", tag, k), md_if.lock, v.exp_lock);
      chk($sformatf("%s[%0d].cfg_mult", tag, k), md_if.cfg_mult, v.exp_mult);
      chk($sformatf("%s[%0d].cfg_idiv", tag, k), md_if.cfg_idiv, v.exp_idiv);
      chk($sformatf("%s[%0d].cfg_odiv", tag, k), md_if.cfg_odiv, v.exp_odiv);
      if (v.exp_commit) start = cyc;
    end
    vq.delete();
    drive_nop();
  endtask

  task automatic wait_lock(input string tag, input logic [7:0] m, input logic [7:0] i,
                           input logic [7:0] o);
    int n;
    n = 0;
    drive_nop();
    while (md_if.lock !== 1'b1 && n < 4 * LOCK_CYCLES) begin
      tick();
      n++;
    end
    chk({tag, ".lock_seen"}, md_if.lock, 1'b1);
    chk({tag, ".lock_delay"}, cyc - start, LOCK_CYCLES);
    chk({tag, ".cfg_mult"}, md_if.cfg_mult, m);
    chk({tag, ".cfg_idiv"}, md_if.cfg_idiv, i);
    chk({tag, ".cfg_odiv"}, md_if.cfg_odiv, o);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, ".mdrdo"}, md_if.mdrdo, 8'h00);
    chk({tag, ".lock"}, md_if.lock, 1'b0);
    chk({tag, ".commit_pulse"}, md_if.commit_pulse, 1'b0);
    chk({tag, ".cfg_mult"}, md_if.cfg_mult, 8'd12);
    chk({tag, ".cfg_idiv"}, md_if.cfg_idiv, 8'd1);
    chk({tag, ".cfg_odiv"}, md_if.cfg_odiv, 8'd1);
  endtask

  initial begin
    reset = 1'b1;
    drive_nop();
    tick();
    tick();
    reset_checks("por");
    exp_hold = 8'h00;
    start = cyc;
    reset = 1'b0;

    // Reset contents, address auto-increment, burst wrap over CTRL, read-after-write
    add(AD, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'd12, 8'd1, 8'd1);
    add(RD, 1'b1, 8'h00, 8'd12, 1'b0, 1'b0, 8'd12, 8'd1, 8'd1);
    add(RD, 1'b1, 8'h00, 8'd1,  1'b0, 1'b0, 8'd12, 8'd1, 8'd1);
    add(RD, 1'b1, 8'h00, 8'd1,  1'b0, 1'b0, 8'd12, 8'd1, 8'd1);
    add(RD, 1'b1, 8'h00, 8'd0,  1'b0, 1'b0, 8'd12, 8'd1, 8'd1);
    add(WR, 1'b0, 8'h5A, 8'h00, 1'b0, 1'b0, 8'd12, 8'd1, 8'd1);
    add(AD, 1'b0, 8'h04, 8'h00, 1'b0, 1'b0, 8'd12, 8'd1, 8'd1);
    add(RD, 1'b0, 8'h00, 8'h5A, 1'b0, 1'b0, 8'd12, 8'd1, 8'd1);
    add(AD, 1'b0, 8'h0E, 8'h00, 1'b0, 1'b0, 8'd12, 8'd1, 8'd1);
    add(WR, 1'b1, 8'hA5, 8'h00, 1'b0, 1'b0, 8'd12, 8'd1, 8'd1);
    add(WR, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'd12, 8'd1, 8'd1);
    add(WR, 1'b1, 8'h3C, 8'h00, 1'b0, 1'b0, 8'd12, 8'd1, 8'd1);
    add(AD, 1'b0, 8'h1E, 8'h00, 1'b0, 1'b0, 8'd12, 8'd1, 8'd1);
    add(RD, 1'b1, 8'h00, 8'hA5, 1'b0, 1'b0, 8'd12, 8'd1, 8'd1);
    add(RD, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'd12, 8'd1, 8'd1);
    add(RD, 1'b0, 8'h00, 8'h3C, 1'b0, 1'b0, 8'd12, 8'd1, 8'd1);
    add(AD, 1'b0, 8'h05, 8'h00, 1'b0, 1'b0, 8'd12, 8'd1, 8'd1);
    add(WR, 1'b0, 8'h99, 8'h00, 1'b0, 1'b0, 8'd12, 8'd1, 8'd1);
    add(RD, 1'b0, 8'h00, 8'h99, 1'b0, 1'b0, 8'd12, 8'd1, 8'd1);
    add(NOP, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'd12, 8'd1, 8'd1);
    add(RD, 1'b0, 8'h00, 8'h99, 1'b0, 1'b0, 8'd12, 8'd1, 8'd1);
    run_table("regs");
    wait_lock("lock_por", 8'd12, 8'd1, 8'd1);

    // Commit while locked
    add(AD, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'd12, 8'd1, 8'd1);
    add(WR, 1'b1, 8'd20, 8'h00, 1'b0, 1'b1, 8'd12, 8'd1, 8'd1);
    add(WR, 1'b0, 8'd2,  8'h00, 1'b0, 1'b1, 8'd12, 8'd1, 8'd1);
    add(AD, 1'b0, 8'h0F, 8'h00, 1'b0, 1'b1, 8'd12, 8'd1, 8'd1);
    add(WR, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'd20, 8'd2, 8'd1);
    add(NOP, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'd20, 8'd2, 8'd1);
    add(RD, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'd20, 8'd2, 8'd1);
    run_table("commit");
    wait_lock("lock_commit", 8'd20, 8'd2, 8'd1);

    // A second commit ten cycles into settle restarts the count
    add(AD, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'd20, 8'd2, 8'd1);
    add(WR, 1'b0, 8'd30, 8'h00, 1'b0, 1'b1, 8'd20, 8'd2, 8'd1);
    add(AD, 1'b0, 8'h0F, 8'h00, 1'b0, 1'b1, 8'd20, 8'd2, 8'd1);
    add(WR, 1'b0, 8'h03, 8'h00, 1'b1, 1'b0, 8'd30, 8'd2, 8'd1);
    for (int k = 0; k < 9; k++) add(NOP, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'd30, 8'd2, 8'd1);
    add(WR, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'd30, 8'd2, 8'd1);
    run_table("recommit");
    wait_lock("lock_recommit", 8'd30, 8'd2, 8'd1);

    // Modified commit, then a one-cycle reset in the middle of settling
    add(AD, 1'b0, 8'h01, 8'h00, 1'b0, 1'b1, 8'd30, 8'd2, 8'd1);
    add(WR, 1'b0, 8'd7,  8'h00, 1'b0, 1'b1, 8'd30, 8'd2, 8'd1);
    add(AD, 1'b0, 8'h0F, 8'h00, 1'b0, 1'b1, 8'd30, 8'd2, 8'd1);
    add(WR, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'd30, 8'd7, 8'd1);
    add(AD, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'd30, 8'd7, 8'd1);
    add(RD, 1'b1, 8'h00, 8'd30, 1'b0, 1'b0, 8'd30, 8'd7, 8'd1);
    add(AD, 1'b0, 8'h09, 8'h00, 1'b0, 1'b0, 8'd30, 8'd7, 8'd1);
    run_table("pre_reset");
    reset = 1'b1;
    tick();
    reset_checks("mid_reset");
    exp_hold = 8'h00;
    start = cyc;
    reset = 1'b0;
    add(RD, 1'b1, 8'h00, 8'd12, 1'b0, 1'b0, 8'd12, 8'd1, 8'd1);
    add(RD, 1'b1, 8'h00, 8'd1,  1'b0, 1'b0, 8'd12, 8'd1, 8'd1);
    run_table("post_reset");
    wait_lock("lock_post_reset", 8'd12, 8'd1, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
